// File: rtl/deshuffle_meta_sched.sv
// Meta-descriptor scheduler for the DeShuffleUnit: arbitrates two load requesters,
// issues meta records and tracks committed beats per request until it drains.
module deshuffle_meta_sched #(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned DLEN     = 64,
  parameter int unsigned VlBits   = 16,
  parameter int unsigned IdBits   = 4,
  parameter int unsigned OutstDep = 4,
  localparam int unsigned BeatBytes = NrLanes * DLEN / 8,
  localparam int unsigned CntBits   = VlBits + 3 - $clog2(BeatBytes),
  localparam int unsigned MetaW     = IdBits + 3 + 2 + 6 + 1 + VlBits + CntBits
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0][IdBits-1:0]       req_id_i,
  input  logic [1:0][2:0]              req_mode_i,
  input  logic [1:0][1:0]              req_sew_i,
  input  logic [1:0][5:0]              req_vd_i,
  input  logic [1:0]                   req_vm_i,
  input  logic [1:0][VlBits-1:0]       req_vstart_i,
  input  logic [1:0][VlBits-1:0]       req_vl_i,
  output logic                         meta_valid_o,
  input  logic                         meta_ready_i,
  output logic [MetaW-1:0]             meta_o,
  input  logic                         cmt_fire_i,
  output logic                         done_valid_o,
  output logic [IdBits-1:0]            done_id_o,
  output logic                         done_src_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned BytesW    = VlBits + 3;
  localparam int unsigned BeatW     = CntBits + 1;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned PtrW      = $clog2(OutstDep);

  typedef struct packed {
    logic [IdBits-1:0] id;
    logic              src;
    logic [BeatW-1:0]  beats;
  } entry_t;

  // Beat count is one wider than cmt_cnt so a full-length request is representable.
  function automatic logic [BeatW-1:0] calcBeats(input logic [VlBits-1:0] vl,
                                                 input logic [VlBits-1:0] vstart,
                                                 input logic [1:0]        sew);
    logic [BytesW-1:0] bytes;
    logic [BytesW:0]   rounded;
    logic [BeatW-1:0]  res;
    bytes   = BytesW'(vl - vstart) << sew;
    rounded = {1'b0, bytes} + (BytesW + 1)'(BeatBytes - 1);
    if (vl <= vstart) res = '0;
    else              res = BeatW'(rounded >> BeatShift);
    return res;
  endfunction

  logic               metaValid_q, metaValid_d;
  logic [MetaW-1:0]   meta_q, meta_d;
  logic               rrPtr_q, rrPtr_d;
  logic [PtrW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntBits-1:0] beatCnt_q, beatCnt_d;
  logic               doneValid_q, doneValid_d;
  logic [IdBits-1:0]  doneId_q, doneId_d;
  logic               doneSrc_q, doneSrc_d;
  logic               zeroPend_q, zeroPend_d;
  logic               err_q, err_d;
  entry_t             queue_q [OutstDep];

  logic [1:0][BeatW-1:0] beats;
  logic [1:0]            zeroLen;
  logic                  cand, slotFree, grant, grantNz, grantZ;
  logic                  empty, full, pop;
  logic [CntBits-1:0]    cmtCnt;
  entry_t                head;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      beats[p]   = calcBeats(req_vl_i[p], req_vstart_i[p], req_sew_i[p]);
      zeroLen[p] = (beats[p] == '0);
    end
  end

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PtrW-1:0] == rdPtr_q[PtrW-1:0]) && (wrPtr_q[PtrW] != rdPtr_q[PtrW]);
  assign head  = queue_q[rdPtr_q[PtrW-1:0]];
  assign pop   = cmt_fire_i && !empty && ({1'b0, beatCnt_q} == head.beats - BeatW'(1));

  // Zero-length requests wait for a fully idle pipe so their done pulse stays in order.
  always_comb begin
    cand = rrPtr_q;
    if (!req_valid_i[rrPtr_q]) cand = ~rrPtr_q;
    slotFree = !metaValid_q || meta_ready_i;
    grant    = 1'b0;
    if (rst_ni && req_valid_i[cand])
      grant = zeroLen[cand] ? (empty && !metaValid_q) : (slotFree && !full);
    grantNz     = grant && !zeroLen[cand];
    grantZ      = grant && zeroLen[cand];
    req_ready_o = grant ? (2'b01 << cand) : 2'b00;
    cmtCnt      = CntBits'(beats[cand] - BeatW'(1));
  end

  always_comb begin
    metaValid_d = metaValid_q;
    meta_d      = meta_q;
    rrPtr_d     = rrPtr_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    beatCnt_d   = beatCnt_q;
    doneValid_d = pop || grantZ;
    doneId_d    = doneId_q;
    doneSrc_d   = doneSrc_q;
    zeroPend_d  = grantZ;
    err_d       = err_q || (cmt_fire_i && empty);

    if (metaValid_q && meta_ready_i) metaValid_d = 1'b0;
    if (grantNz) begin
      metaValid_d = 1'b1;
      meta_d      = {req_id_i[cand], req_mode_i[cand], req_sew_i[cand], req_vd_i[cand],
                     req_vm_i[cand], req_vstart_i[cand], cmtCnt};
      wrPtr_d     = wrPtr_q + 1'b1;
    end
    if (grant) rrPtr_d = ~cand;

    if (cmt_fire_i && !empty) begin
      if (pop) begin
        beatCnt_d = '0;
        rdPtr_d   = rdPtr_q + 1'b1;
        doneId_d  = head.id;
        doneSrc_d = head.src;
      end else begin
        beatCnt_d = beatCnt_q + 1'b1;
      end
    end
    if (grantZ) begin
      doneId_d  = req_id_i[cand];
      doneSrc_d = cand;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      metaValid_q <= 1'b0;
      meta_q      <= '0;
      rrPtr_q     <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      beatCnt_q   <= '0;
      doneValid_q <= 1'b0;
      doneId_q    <= '0;
      doneSrc_q   <= 1'b0;
      zeroPend_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      metaValid_q <= metaValid_d;
      meta_q      <= meta_d;
      rrPtr_q     <= rrPtr_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      beatCnt_q   <= beatCnt_d;
      doneValid_q <= doneValid_d;
      doneId_q    <= doneId_d;
      doneSrc_q   <= doneSrc_d;
      zeroPend_q  <= zeroPend_d;
      err_q       <= err_d;
    end
  end

  // Entry storage needs no reset: the pointers alone define which slots are live.
  always_ff @(posedge clk_i) begin
    if (grantNz) queue_q[wrPtr_q[PtrW-1:0]] <= '{id: req_id_i[cand], src: cand, beats: beats[cand]};
  end

  assign meta_valid_o = metaValid_q;
  assign meta_o       = meta_q;
  assign done_valid_o = doneValid_q;
  assign done_id_o    = doneId_q;
  assign done_src_o   = doneSrc_q;
  assign busy_o       = metaValid_q || !empty || zeroPend_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_deshuffle_meta_sched.sv
// Directed bench for deshuffle_meta_sched: inputs are driven and outputs sampled on the
// falling clock edge, with expected values worked out by hand for the default parameters.
module tb_deshuffle_meta_sched;

  logic             clk = 1'b0;
  logic             rstN;
  logic [1:0]       reqValid, reqReady;
  logic [1:0][3:0]  reqId;
  logic [1:0][2:0]  reqMode;
  logic [1:0][1:0]  reqSew;
  logic [1:0][5:0]  reqVd;
  logic [1:0]       reqVm;
  logic [1:0][15:0] reqVstart, reqVl;
  logic             metaValid, metaReady;
  logic [45:0]      meta;
  logic             cmtFire, doneValid, doneSrc, busy, err;
  logic [3:0]       doneId;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  deshuffle_meta_sched dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_id_i(reqId), .req_mode_i(reqMode), .req_sew_i(reqSew), .req_vd_i(reqVd),
    .req_vm_i(reqVm), .req_vstart_i(reqVstart), .req_vl_i(reqVl),
    .meta_valid_o(metaValid), .meta_ready_i(metaReady), .meta_o(meta),
    .cmt_fire_i(cmtFire), .done_valid_o(doneValid), .done_id_o(doneId),
    .done_src_o(doneSrc), .busy_o(busy), .err_o(err)
  );

  // Mode, vd and vm are derived from port and id so every meta field is distinguishable.
  task automatic setReq(input logic p, input logic [3:0] id, input logic [1:0] sew,
                        input logic [15:0] vstart, input logic [15:0] vl);
    reqId[p]     = id;
    reqMode[p]   = p ? 3'b101 : 3'b010;
    reqSew[p]    = sew;
    reqVd[p]     = {2'b10, id};
    reqVm[p]     = ~p;
    reqVstart[p] = vstart;
    reqVl[p]     = vl;
  endtask

  function automatic logic [45:0] expMeta(input logic p, input logic [3:0] id, input logic [1:0] sew,
                                          input logic [15:0] vstart, input logic [13:0] cnt);
    return {id, (p ? 3'b101 : 3'b010), sew, {2'b10, id}, ~p, vstart, cnt};
  endfunction

  task automatic test_reset();
    setReq(1'b0, 4'd1, 2'd2, 16'd0, 16'd8);
    setReq(1'b1, 4'd2, 2'd2, 16'd0, 16'd8);
    reqValid = 2'b11;
    repeat (2) @(negedge clk);
    totalCnt++; if (metaValid !== 1'b0) $display("[TB] FAIL reset_meta_valid: got %b expected 0", metaValid); else passCnt++;
    totalCnt++; if (meta !== 46'd0) $display("[TB] FAIL reset_meta: got %h expected 0", meta); else passCnt++;
    totalCnt++; if ({doneValid, doneId, doneSrc} !== 6'd0) $display("[TB] FAIL reset_done: got %b%h%b expected 0", doneValid, doneId, doneSrc); else passCnt++;
    totalCnt++; if ({err, busy} !== 2'b00) $display("[TB] FAIL reset_err_busy: got %b%b expected 00", err, busy); else passCnt++;
    totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL reset_ready: got %b expected 00", reqReady); else passCnt++;
    reqValid = 2'b00;
    rstN     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    setReq(1'b0, 4'd3, 2'd2, 16'd0, 16'd20);
    reqValid = 2'b01;
    #1;
    totalCnt++; if (reqReady !== 2'b01) $display("[TB] FAIL single_ready: got %b expected 01", reqReady); else passCnt++;
    @(negedge clk);
    reqValid = 2'b00;
    totalCnt++; if (metaValid !== 1'b1) $display("[TB] FAIL single_meta_valid: got %b expected 1", metaValid); else passCnt++;
    totalCnt++; if (meta !== expMeta(1'b0, 4'd3, 2'd2, 16'd0, 14'd2)) $display("[TB] FAIL single_meta: got %h expected %h", meta, expMeta(1'b0, 4'd3, 2'd2, 16'd0, 14'd2)); else passCnt++;
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passCnt++;
    for (int i = 0; i < 3; i++) begin
      cmtFire = 1'b1;
      @(negedge clk);
      totalCnt++; if (doneValid !== (i == 2)) $display("[TB] FAIL single_done_valid beat %0d: got %b expected %b", i, doneValid, (i == 2)); else passCnt++;
    end
    cmtFire = 1'b0;
    totalCnt++; if ({doneId, doneSrc} !== {4'd3, 1'b0}) $display("[TB] FAIL single_done_id_src: got %h/%b expected 3/0", doneId, doneSrc); else passCnt++;
    @(negedge clk);
    totalCnt++; if ({doneValid, busy} !== 2'b00) $display("[TB] FAIL single_idle: got %b%b expected 00", doneValid, busy); else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic grantSeq [4];
    grantSeq = '{1'b1, 1'b0, 1'b1, 1'b0};
    setReq(1'b0, 4'd4, 2'd2, 16'd0, 16'd8);
    setReq(1'b1, 4'd9, 2'd2, 16'd0, 16'd8);
    reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      totalCnt++; if (reqReady !== (grantSeq[i] ? 2'b10 : 2'b01)) $display("[TB] FAIL rr_ready grant %0d: got %b expected port %0d", i, reqReady, grantSeq[i]); else passCnt++;
      @(negedge clk);
      totalCnt++; if ({metaValid, meta} !== {1'b1, expMeta(grantSeq[i], grantSeq[i] ? 4'd9 : 4'd4, 2'd2, 16'd0, 14'd0)}) $display("[TB] FAIL rr_meta grant %0d: got %b/%h", i, metaValid, meta); else passCnt++;
    end
    #1;
    totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL rr_full_ready: got %b expected 00", reqReady); else passCnt++;
    reqValid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      cmtFire = 1'b1;
      @(negedge clk);
      totalCnt++; if ({doneValid, doneId, doneSrc} !== {1'b1, (grantSeq[i] ? 4'd9 : 4'd4), grantSeq[i]}) $display("[TB] FAIL rr_done_order %0d: got %b/%h/%b expected 1/%h/%b", i, doneValid, doneId, doneSrc, (grantSeq[i] ? 4'd9 : 4'd4), grantSeq[i]); else passCnt++;
    end
    cmtFire = 1'b0;
  endtask

  task automatic test_backpressure();
    metaReady = 1'b0;
    setReq(1'b0, 4'd6, 2'd0, 16'd0, 16'd64);
    reqValid = 2'b01;
    #1;
    totalCnt++; if (reqReady !== 2'b01) $display("[TB] FAIL bp_first_ready: got %b expected 01", reqReady); else passCnt++;
    @(negedge clk);
    setReq(1'b1, 4'd11, 2'd2, 16'd0, 16'd8);
    reqValid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      totalCnt++; if ({metaValid, meta} !== {1'b1, expMeta(1'b0, 4'd6, 2'd0, 16'd0, 14'd1)}) $display("[TB] FAIL bp_meta_hold cycle %0d: got %b/%h", i, metaValid, meta); else passCnt++;
      #1;
      totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL bp_stall_ready cycle %0d: got %b expected 00", i, reqReady); else passCnt++;
      @(negedge clk);
    end
    metaReady = 1'b1;
    #1;
    totalCnt++; if (reqReady !== 2'b10) $display("[TB] FAIL bp_release_ready: got %b expected 10", reqReady); else passCnt++;
    @(negedge clk);
    reqValid = 2'b00;
    totalCnt++; if ({metaValid, meta} !== {1'b1, expMeta(1'b1, 4'd11, 2'd2, 16'd0, 14'd0)}) $display("[TB] FAIL bp_second_meta: got %b/%h", metaValid, meta); else passCnt++;
    @(negedge clk);
    totalCnt++; if (metaValid !== 1'b0) $display("[TB] FAIL bp_meta_drop: got %b expected 0", metaValid); else passCnt++;
    cmtFire = 1'b1;
    @(negedge clk);
    totalCnt++; if (doneValid !== 1'b0) $display("[TB] FAIL bp_done_early: got %b expected 0", doneValid); else passCnt++;
    @(negedge clk);
    totalCnt++; if ({doneValid, doneId, doneSrc} !== {1'b1, 4'd6, 1'b0}) $display("[TB] FAIL bp_done_first: got %b/%h/%b expected 1/6/0", doneValid, doneId, doneSrc); else passCnt++;
    @(negedge clk);
    cmtFire = 1'b0;
    totalCnt++; if ({doneValid, doneId, doneSrc} !== {1'b1, 4'd11, 1'b1}) $display("[TB] FAIL bp_done_second: got %b/%h/%b expected 1/b/1", doneValid, doneId, doneSrc); else passCnt++;
  endtask

  task automatic test_queue_full();
    for (int i = 0; i < 4; i++) begin
      setReq(1'b0, 4'(i + 1), 2'd2, 16'd0, 16'd8);
      reqValid = 2'b01;
      #1;
      totalCnt++; if (reqReady !== 2'b01) $display("[TB] FAIL qf_fill_ready %0d: got %b expected 01", i, reqReady); else passCnt++;
      @(negedge clk);
    end
    setReq(1'b0, 4'd5, 2'd2, 16'd0, 16'd8);
    cmtFire = 1'b1;
    #1;
    totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL qf_full_ready: got %b expected 00", reqReady); else passCnt++;
    @(negedge clk);
    cmtFire = 1'b0;
    totalCnt++; if ({doneValid, doneId} !== {1'b1, 4'd1}) $display("[TB] FAIL qf_pop_done: got %b/%h expected 1/1", doneValid, doneId); else passCnt++;
    #1;
    totalCnt++; if (reqReady !== 2'b01) $display("[TB] FAIL qf_reopen_ready: got %b expected 01", reqReady); else passCnt++;
    @(negedge clk);
    reqValid = 2'b00;
    totalCnt++; if ({metaValid, meta} !== {1'b1, expMeta(1'b0, 4'd5, 2'd2, 16'd0, 14'd0)}) $display("[TB] FAIL qf_next_meta: got %b/%h", metaValid, meta); else passCnt++;
    for (int i = 0; i < 4; i++) begin
      cmtFire = 1'b1;
      @(negedge clk);
      totalCnt++; if ({doneValid, doneId} !== {1'b1, 4'(i + 2)}) $display("[TB] FAIL qf_drain %0d: got %b/%h expected 1/%h", i, doneValid, doneId, 4'(i + 2)); else passCnt++;
    end
    cmtFire = 1'b0;
  endtask

  task automatic test_zero_length();
    setReq(1'b0, 4'd7, 2'd2, 16'd0, 16'd8);
    reqValid = 2'b01;
    #1;
    totalCnt++; if (reqReady !== 2'b01) $display("[TB] FAIL zl_head_ready: got %b expected 01", reqReady); else passCnt++;
    @(negedge clk);
    setReq(1'b1, 4'd12, 2'd2, 16'd5, 16'd5);
    reqValid = 2'b10;
    #1;
    totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL zl_stall_meta: got %b expected 00", reqReady); else passCnt++;
    @(negedge clk);
    totalCnt++; if (metaValid !== 1'b0) $display("[TB] FAIL zl_meta_clear: got %b expected 0", metaValid); else passCnt++;
    cmtFire = 1'b1;
    #1;
    totalCnt++; if (reqReady !== 2'b00) $display("[TB] FAIL zl_stall_queue: got %b expected 00", reqReady); else passCnt++;
    @(negedge clk);
    cmtFire = 1'b0;
    totalCnt++; if ({doneValid, doneId, doneSrc} !== {1'b1, 4'd7, 1'b0}) $display("[TB] FAIL zl_head_done: got %b/%h/%b expected 1/7/0", doneValid, doneId, doneSrc); else passCnt++;
    #1;
    totalCnt++; if (reqReady !== 2'b10) $display("[TB] FAIL zl_grant_ready: got %b expected 10", reqReady); else passCnt++;
    @(negedge clk);
    reqValid = 2'b00;
    totalCnt++; if ({doneValid, doneId, doneSrc, metaValid, busy} !== {1'b1, 4'd12, 1'b1, 1'b0, 1'b1}) $display("[TB] FAIL zl_done: got %b/%h/%b meta %b busy %b expected 1/c/1 meta 0 busy 1", doneValid, doneId, doneSrc, metaValid, busy); else passCnt++;
    @(negedge clk);
    totalCnt++; if ({doneValid, metaValid, busy} !== 3'b000) $display("[TB] FAIL zl_after: got %b%b%b expected 000", doneValid, metaValid, busy); else passCnt++;
  endtask

  task automatic test_error_and_abort();
    cmtFire = 1'b1;
    @(negedge clk);
    cmtFire = 1'b0;
    totalCnt++; if (err !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", err); else passCnt++;
    repeat (3) @(negedge clk);
    totalCnt++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err); else passCnt++;
    setReq(1'b0, 4'd2, 2'd2, 16'd0, 16'd80);
    reqValid = 2'b01;
    @(negedge clk);
    totalCnt++; if ({metaValid, meta} !== {1'b1, expMeta(1'b0, 4'd2, 2'd2, 16'd0, 14'd9)}) $display("[TB] FAIL abort_meta: got %b/%h", metaValid, meta); else passCnt++;
    cmtFire = 1'b1;
    @(negedge clk);
    cmtFire = 1'b0;
    totalCnt++; if (busy !== 1'b1) $display("[TB] FAIL abort_busy: got %b expected 1", busy); else passCnt++;
    #2 rstN = 1'b0;
    #1;
    totalCnt++; if ({metaValid, meta} !== 47'd0) $display("[TB] FAIL abort_meta_reset: got %b/%h expected 0/0", metaValid, meta); else passCnt++;
    totalCnt++; if ({err, busy, doneValid, reqReady} !== 5'd0) $display("[TB] FAIL abort_status_reset: got err %b busy %b done %b ready %b expected all 0", err, busy, doneValid, reqReady); else passCnt++;
    @(negedge clk);
    reqValid = 2'b00;
    rstN     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      totalCnt++; if ({doneValid, busy, metaValid} !== 3'b000) $display("[TB] FAIL abort_quiet %0d: got %b%b%b expected 000", i, doneValid, busy, metaValid); else passCnt++;
    end
  endtask

  initial begin
    rstN      = 1'b0;
    reqValid  = 2'b00;
    reqId     = '0;
    reqMode   = '0;
    reqSew    = '0;
    reqVd     = '0;
    reqVm     = '0;
    reqVstart = '0;
    reqVl     = '0;
    metaReady = 1'b1;
    cmtFire   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_queue_full();
    test_zero_length();
    test_error_and_abort();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, checks so far %0d/%0d", passCnt, totalCnt);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/deshuffle_meta_sched.md
Name: deshuffle_meta_sched

Overview:
- Schedules load-writeback meta descriptors from two requesters onto the single DeShuffleUnit meta channel.
  - Port 0 is the unit-stride/strided load path; port 1 is the 2D-cln path.
- Per request, the block:
  - computes the commit-beat count,
  - issues the meta record downstream,
  - tracks outstanding requests in issue order,
  - counts shuffle→sequential commit beats,
  - emits a completion pulse when each request has fully drained.
- Sits between the VLSU request dispatcher and the DeShuffleUnit.

Parameters:
- NrLanes, 4, number of lanes; power of two.
- DLEN, 64, per-lane datapath bits. BeatBytes = NrLanes*DLEN/8 (32 at defaults).
- VlBits, 16, width of vl/vstart.
- IdBits, 4, req_id width.
- OutstDep, 4, tracking-queue depth; power of two, ≥2.
- CntBits, VlBits+3-$clog2(BeatBytes), width of cmt_cnt.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester valid
- req_ready_o  out  2  per-requester ready
- req_id_i  in  2xIdBits  request id
- req_mode_i  in  2x3  mode (2D-cln encoding passes through unchanged)
- req_sew_i  in  2x2  element width, log2 bytes
- req_vd_i  in  2x6  destination register
- req_vm_i  in  2  1 = unmasked
- req_vstart_i  in  2xVlBits  start element
- req_vl_i  in  2xVlBits  vector length
- meta_valid_o  out  1  meta record valid to DeShuffleUnit
- meta_ready_i  in  1  DeShuffleUnit meta ready
- meta_o  out  IdBits+3+2+6+1+VlBits+CntBits  {req_id, mode, sew, vd, vm, vstart, cmt_cnt}
- cmt_fire_i  in  1  one pulse per committed beat (valid&&ready of the DeShuffleUnit seq-store output)
- done_valid_o  out  1  one-cycle completion pulse
- done_id_o  out  IdBits  completed req_id
- done_src_o  out  1  requester index of the completed request
- busy_o  out  1  any request in flight
- err_o  out  1  sticky protocol error

Behaviour:
- Single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: meta_valid_o=0, meta_o=0, done_valid_o=0, done_id_o=0, done_src_o=0, err_o=0, tracking queue empty, beat counter=0, RR pointer=0. req_ready_o is 0 during reset.
- Length arithmetic:
  - bytes = (vl - vstart) << sew, computed in VlBits+3 bits.
  - beats = ceil(bytes / BeatBytes).
  - cmt_cnt = beats - 1, truncated to CntBits.
  - vl ≤ vstart is a zero-length request (beats = 0).
- Arbitration:
  - Round-robin over ports with pending valid. The pointer points at the preferred port and moves to the other port after every grant.
  - req_ready_o[p] is 1 only for the granted port p, and only when:
    - the output slot is free or draining (!meta_valid_o || meta_ready_i), and
    - the tracking queue is not full.
  - Zero-length requests are granted only when the tracking queue is empty and meta_valid_o=0.
  - At most one grant per cycle.
- Issue:
  - A non-zero grant registers meta_o and sets meta_valid_o the next cycle.
  - In the same cycle it enqueues {req_id, src, beats} into the tracking queue.
  - meta_o is held stable while meta_valid_o && !meta_ready_i.
  - Latency from request handshake to meta_valid_o is 1 cycle.
- Zero-length: nothing is issued downstream. done_valid_o pulses the cycle after the grant with that request's id and src.
- Tracking:
  - Each cmt_fire_i increments the head's beat counter.
  - When cmt_fire_i arrives with counter == beats-1:
    - pop the head and reset the counter to 0;
    - done_valid_o, done_id_o and done_src_o are registered, so the pulse appears the next cycle.
  - Enqueue and pop in the same cycle are both performed. A full queue with a simultaneous pop still blocks the grant that cycle (ready is computed from the registered full flag).
  - Queue pointers use a wrap flag: empty = equal values with equal flags; full = equal values with differing flags.
- Errors: err_o is set (sticky until reset) on cmt_fire_i while the queue is empty; the fire is otherwise ignored.
- busy_o = meta_valid_o || queue non-empty || zero-length done pending.
- Reset mid-operation: all state, including queued entries and a pending done pulse, is discarded. No done pulse is emitted for aborted requests.

Test Plan:
- Defaults (BeatBytes=32); port0: vl=20, vstart=0, sew=2, id=3 → next cycle meta_valid_o=1 with cmt_cnt=2. Then 3 cmt_fire_i pulses → done_valid_o one cycle after the 3rd pulse, done_id_o=3, done_src_o=0.
- Both ports valid continuously with 1-beat requests (vl=8, sew=2) and meta_ready_i=1 → grants alternate 0,1,0,1. cmt_cnt=0 each time. Done order matches issue order.
- meta_ready_i=0 for 5 cycles with port0 valid → meta_o stable and req_ready_o=0 for port1 until the handshake completes.
- Issue 4 requests with no cmt_fire_i → queue full, req_ready_o=00. One completion drains an entry → the next request is accepted the following cycle.
- Port1 vl=5, vstart=5 while the queue holds 1 entry → port1 stalled until that entry completes. Then grant, done_valid_o=1 with done_src_o=1, and meta_valid_o never asserts for it.
- cmt_fire_i with the queue empty → err_o=1 and remains set. Assert rst_ni low mid-transfer → all outputs return to reset values asynchronously.
